// File: rtl/cpu_mc_pkg.sv
// Shared types for the multi-cycle core: opcode and sequencer state enumerations.
package cpu_mc_pkg;

    localparam int unsigned OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_ADDI = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_NOT  = 4'h6,
        OP_LW   = 4'h7,
        OP_SW   = 4'h8,
        OP_WO   = 4'h9,
        OP_RO   = 4'hA,
        OP_COPY = 4'hB,
        OP_JEQ  = 4'hC,
        OP_ZERO = 4'hD,
        OP_HALT = 4'hE,
        OP_JMP  = 4'hF
    } e_instr;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_HALT  = 3'd4
    } e_cpu_state;

    // Loads and stores leave EXEC for the data-memory handshake.
    function automatic logic is_mem_op(input e_instr op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/cpu_mc_regfile.sv
// Register file: REG_N x WORD_W, two asynchronous read ports, one synchronous write port.
// Ports: ra_addr/ra_data, rb_addr/rb_data read ports; we/waddr/wdata write port;
//        clk, rst (asynchronous, active-low, clears every register).
module cpu_mc_regfile
    import cpu_mc_pkg::*;
#(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ra_addr,
    output logic [WORD_W-1:0] ra_data,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [WORD_W-1:0] rb_data,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [WORD_W-1:0] wdata
);

    localparam int unsigned REG_N = 2 ** REG_AW;

    logic [WORD_W-1:0] regs [REG_N];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < REG_N; i++) begin
                regs[REG_AW'(i)] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign ra_data = regs[ra_addr];
    assign rb_data = regs[rb_addr];

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle core: IDLE -> FETCH -> EXEC [-> MEM] -> FETCH, with valid/ack handshakes
// on separate instruction and data ports, HALT and unconditional/conditional jumps.
// Ports: clk, rst (asynchronous, active-low); imem_req/addr/ack/instr/imm fetch port;
//        dmem_req/we/addr/wdata/ack/rdata data port; in_data (RO), out_data (WO); halted.
// Build option: CPU_MC_PERF_EN adds perf_retired[31:0], a count of committed instructions.
module cpu_mc
    import cpu_mc_pkg::*;
#(
    parameter  int unsigned WORD_W  = 8,
    parameter  int unsigned REG_AW  = 2,
    parameter  int unsigned PC_W    = 8,
    localparam int unsigned INSTR_W = 4 + 2 * REG_AW
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic [WORD_W-1:0]  imem_imm,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [WORD_W-1:0]  dmem_addr,
    output logic [WORD_W-1:0]  dmem_wdata,
    input  logic               dmem_ack,
    input  logic [WORD_W-1:0]  dmem_rdata,
    input  logic [WORD_W-1:0]  in_data,
    output logic [WORD_W-1:0]  out_data,
    output logic               halted
`ifdef CPU_MC_PERF_EN
    ,
    output logic [31:0]        perf_retired
`endif
);

    e_cpu_state         state;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [WORD_W-1:0]  imm;

    e_instr             op;
    logic [REG_AW-1:0]  rs_addr;
    logic [REG_AW-1:0]  rt_addr;
    logic [WORD_W-1:0]  rs_val;
    logic [WORD_W-1:0]  rt_val;
    logic [WORD_W-1:0]  alu_b;
    logic [WORD_W-1:0]  alu_y;
    logic               alu_zero;
    logic               take_jump;
    logic               wr_en;
    logic [WORD_W-1:0]  wr_data;
    logic [PC_W-1:0]    pc_inc;

    assign op        = e_instr'(instr[3:0]);
    assign rs_addr   = instr[3+REG_AW:4];
    assign rt_addr   = instr[INSTR_W-1:4+REG_AW];
    assign imem_addr = pc;
    assign pc_inc    = pc + PC_W'(1);

    cpu_mc_regfile #(
        .WORD_W (WORD_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .ra_addr (rs_addr),
        .ra_data (rs_val),
        .rb_addr (rt_addr),
        .rb_data (rt_val),
        .we      (wr_en),
        .waddr   (rs_addr),
        .wdata   (wr_data)
    );

    // ALU; JEQ reuses the subtractor and tests its zero result.
    always_comb begin
        alu_b = (op == OP_ADDI) ? imm : rt_val;
        alu_y = '0;
        case (op)
            OP_ADD, OP_ADDI: alu_y = rs_val + alu_b;
            OP_SUB, OP_JEQ:  alu_y = rs_val - alu_b;
            OP_AND:          alu_y = rs_val & alu_b;
            OP_OR:           alu_y = rs_val | alu_b;
            OP_NOT:          alu_y = ~alu_b;
            default:         alu_y = '0;
        endcase
        alu_zero  = (alu_y == '0);
        take_jump = (op == OP_JMP) || ((op == OP_JEQ) && alu_zero);
    end

    // Register write-back: EXEC for ALU/move ops, MEM ack cycle for loads.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = alu_y;
        if (state == ST_EXEC) begin
            case (op)
                OP_ADD, OP_ADDI, OP_SUB, OP_AND, OP_OR, OP_NOT: wr_en = 1'b1;
                OP_RO:   begin wr_en = 1'b1; wr_data = in_data; end
                OP_COPY: begin wr_en = 1'b1; wr_data = rt_val;  end
                OP_ZERO: begin wr_en = 1'b1; wr_data = '0;      end
                default: wr_en = 1'b0;
            endcase
        end else if ((state == ST_MEM) && dmem_ack && !dmem_we) begin
            wr_en   = 1'b1;
            wr_data = dmem_rdata;
        end
    end

    // Sequencer with registered handshake outputs; async reset drops requests immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            pc         <= '0;
            instr      <= '0;
            imm        <= '0;
            out_data   <= '0;
            halted     <= 1'b0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr    <= imem_instr;
                        imm      <= imem_imm;
                        imem_req <= 1'b0;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (is_mem_op(op)) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= (op == OP_SW);
                        dmem_addr  <= (op == OP_SW) ? rs_val : rt_val;
                        dmem_wdata <= rt_val;
                        state      <= ST_MEM;
                    end else if (op == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else begin
                        if (op == OP_WO) begin
                            out_data <= rs_val;
                        end
                        pc       <= take_jump ? PC_W'(imm) : pc_inc;
                        imem_req <= 1'b1;
                        state    <= ST_FETCH;
                    end
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        pc       <= pc_inc;
                        imem_req <= 1'b1;
                        state    <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CPU_MC_PERF_EN
    // Retired-instruction counter: every EXEC that does not go to MEM, plus each MEM ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_retired <= '0;
        end else if (((state == ST_EXEC) && !is_mem_op(op)) ||
                     ((state == ST_MEM) && dmem_ack)) begin
            perf_retired <= perf_retired + 32'd1;
        end
    end
`else
    // Retired-instruction counter not built.
`endif

endmodule

// File: tb/tb_cpu_mc.sv
// Self-checking bench for cpu_mc: instruction/data memory models with programmable wait
// states record what the core does; each test pushes expected fetch addresses, WO values
// and data accesses, then pops and compares them against the recorded observations.
module tb_cpu_mc;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       stable;
    } dacc_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_instr;
    logic [7:0] imem_imm;
    logic       dmem_req;
    logic       dmem_we;
    logic [7:0] dmem_addr;
    logic [7:0] dmem_wdata;
    logic       dmem_ack;
    logic [7:0] dmem_rdata;
    logic [7:0] in_data = 8'h00;
    logic [7:0] out_data;
    logic       halted;
`ifdef CPU_MC_PERF_EN
    logic [31:0] perf_retired;
`endif

    logic       dack_model;
    logic       dack_force = 1'b0;
    assign dmem_ack = dack_model | dack_force;

    int errors = 0;
    int checks = 0;

    int iwait = 0;
    int dwait = 0;

    logic [7:0] imem_i [256];
    logic [7:0] imem_d [256];
    logic [7:0] dmem   [256];

    logic [7:0] exp_fetch_q [$];
    logic [7:0] obs_fetch_q [$];
    logic [7:0] exp_out_q   [$];
    logic [7:0] obs_out_q   [$];
    dacc_t      exp_dacc_q  [$];
    dacc_t      obs_dacc_q  [$];

    always #5 clk = ~clk;

    cpu_mc dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_instr (imem_instr),
        .imem_imm   (imem_imm),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .in_data    (in_data),
        .out_data   (out_data),
        .halted     (halted)
`ifdef CPU_MC_PERF_EN
        ,
        .perf_retired (perf_retired)
`endif
    );

    // Instruction memory model: acks after iwait waiting cycles, records each fetch and
    // the out_data value visible once the instruction after a WO is being fetched.
    int   icnt;
    logic last_wo;
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            imem_ack   = 1'b0;
            imem_instr = 8'h00;
            imem_imm   = 8'h00;
            icnt       = 0;
            last_wo    = 1'b0;
        end else begin
            imem_ack = 1'b0;
            if (imem_req) begin
                if (icnt >= iwait) begin
                    icnt       = 0;
                    imem_ack   = 1'b1;
                    imem_instr = imem_i[imem_addr];
                    imem_imm   = imem_d[imem_addr];
                    obs_fetch_q.push_back(imem_addr);
                    if (last_wo) obs_out_q.push_back(out_data);
                    last_wo = (imem_instr[3:0] == 4'h9);
                end else begin
                    icnt++;
                end
            end
        end
    end

    // Data memory model: acks after dwait waiting cycles, notes whether the request stayed stable.
    int         dcnt;
    logic [7:0] d_addr0;
    logic [7:0] d_wdata0;
    logic       d_we0;
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            dack_model = 1'b0;
            dmem_rdata = 8'h00;
            dcnt       = 0;
        end else begin
            dack_model = 1'b0;
            if (dmem_req) begin
                if (dcnt == 0) begin
                    d_addr0  = dmem_addr;
                    d_wdata0 = dmem_wdata;
                    d_we0    = dmem_we;
                end
                if (dcnt >= dwait) begin
                    dcnt       = 0;
                    dack_model = 1'b1;
                    obs_dacc_q.push_back('{we: dmem_we, addr: dmem_addr, wdata: dmem_wdata,
                        stable: (dmem_addr == d_addr0) && (dmem_wdata == d_wdata0) && (dmem_we == d_we0)});
                    if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                    else         dmem_rdata = dmem[dmem_addr];
                end else begin
                    dcnt++;
                end
            end
        end
    end

    function automatic logic [7:0] enc(input logic [3:0] op, input logic [1:0] rs, input logic [1:0] rt);
        return {rt, rs, op};
    endfunction

    task automatic put(input int a, input logic [3:0] op, input logic [1:0] rs,
                       input logic [1:0] rt, input logic [7:0] imm);
        imem_i[a] = enc(op, rs, rt);
        imem_d[a] = imm;
    endtask

    // Hold reset, clear the memories (HALT everywhere) and all scoreboard queues.
    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            imem_i[i] = 8'h0E;
            imem_d[i] = 8'h00;
        end
        exp_fetch_q.delete(); obs_fetch_q.delete();
        exp_out_q.delete();   obs_out_q.delete();
        exp_dacc_q.delete();  obs_dacc_q.delete();
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic run_to_halt(input string tag, input int max_cyc, output int cyc);
        cyc = 0;
        while (cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (halted) break;
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL %s halt_timeout: halted=%b after %0d cycles, required 1", tag, halted, cyc);
        end
    endtask

    // Pop expected vs observed fetches, WO values and data accesses; leftovers are failures.
    task automatic drain_scoreboard(input string tag);
        logic [7:0] e8, o8;
        dacc_t      ed, od;
        while (exp_fetch_q.size() > 0 && obs_fetch_q.size() > 0) begin
            e8 = exp_fetch_q.pop_front(); o8 = obs_fetch_q.pop_front();
            checks++;
            if (o8 !== e8) begin
                errors++;
                $display("FAIL %s fetch_addr: got 0x%02h required 0x%02h", tag, o8, e8);
            end
        end
        while (exp_out_q.size() > 0 && obs_out_q.size() > 0) begin
            e8 = exp_out_q.pop_front(); o8 = obs_out_q.pop_front();
            checks++;
            if (o8 !== e8) begin
                errors++;
                $display("FAIL %s out_data: got 0x%02h required 0x%02h", tag, o8, e8);
            end
        end
        while (exp_dacc_q.size() > 0 && obs_dacc_q.size() > 0) begin
            ed = exp_dacc_q.pop_front(); od = obs_dacc_q.pop_front();
            checks++;
            if (od.we !== ed.we || od.addr !== ed.addr || od.stable !== 1'b1 ||
                (ed.we && od.wdata !== ed.wdata)) begin
                errors++;
                $display("FAIL %s dmem_access: got we=%b addr=0x%02h wdata=0x%02h stable=%b required we=%b addr=0x%02h wdata=0x%02h stable=1",
                         tag, od.we, od.addr, od.wdata, od.stable, ed.we, ed.addr, ed.wdata);
            end
        end
        checks++;
        if (exp_fetch_q.size() + obs_fetch_q.size() + exp_out_q.size() + obs_out_q.size() +
            exp_dacc_q.size() + obs_dacc_q.size() != 0) begin
            errors++;
            $display("FAIL %s leftovers: exp/obs fetch %0d/%0d out %0d/%0d dmem %0d/%0d, required all 0",
                     tag, exp_fetch_q.size(), obs_fetch_q.size(), exp_out_q.size(), obs_out_q.size(),
                     exp_dacc_q.size(), obs_dacc_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || dmem_req !== 1'b0 || dmem_we !== 1'b0 || imem_addr !== 8'h00 ||
            out_data !== 8'h00 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: imem_req=%b dmem_req=%b dmem_we=%b pc=0x%02h out=0x%02h halted=%b, required all 0",
                     imem_req, dmem_req, dmem_we, imem_addr, out_data, halted);
        end
    endtask

    task automatic test_alu_seq();
        int cyc;
        do_reset();
        iwait = 0; dwait = 0;
        put(0, 4'h2, 2'd0, 2'd0, 8'h05);   // ADDI r0,5
        put(1, 4'h2, 2'd1, 2'd0, 8'h03);   // ADDI r1,3
        put(2, 4'h1, 2'd0, 2'd1, 8'h00);   // ADD  r0,r1
        put(3, 4'h9, 2'd0, 2'd0, 8'h00);   // WO   r0
        for (int a = 0; a <= 4; a++) exp_fetch_q.push_back(8'(a));
        exp_out_q.push_back(8'h08);
        release_reset();
        run_to_halt("alu_seq", 100, cyc);
        // IDLE 1 + four 2-cycle instructions + HALT fetch/exec 2
        checks++;
        if (cyc !== 11) begin
            errors++;
            $display("FAIL alu_seq cycles: got %0d required 11", cyc);
        end
        checks++;
        if (imem_addr !== 8'h04 || out_data !== 8'h08) begin
            errors++;
            $display("FAIL alu_seq final: pc=0x%02h out=0x%02h required pc=0x04 out=0x08", imem_addr, out_data);
        end
`ifdef CPU_MC_PERF_EN
        checks++;
        if (perf_retired !== 32'd5) begin
            errors++;
            $display("FAIL alu_seq perf_retired: got %0d required 5", perf_retired);
        end
`endif
        drain_scoreboard("alu_seq");
    endtask

    task automatic test_mem_wait();
        int cyc;
        do_reset();
        iwait = 0; dwait = 3;
        put(0, 4'h2, 2'd0, 2'd0, 8'h20);   // ADDI r0,0x20
        put(1, 4'h2, 2'd1, 2'd0, 8'h03);   // ADDI r1,3
        put(2, 4'h8, 2'd0, 2'd1, 8'h00);   // SW   mem[r0]<-r1
        put(3, 4'h7, 2'd2, 2'd0, 8'h00);   // LW   r2<-mem[r0]
        put(4, 4'h9, 2'd2, 2'd0, 8'h00);   // WO   r2
        for (int a = 0; a <= 5; a++) exp_fetch_q.push_back(8'(a));
        exp_dacc_q.push_back('{we: 1'b1, addr: 8'h20, wdata: 8'h03, stable: 1'b1});
        exp_dacc_q.push_back('{we: 1'b0, addr: 8'h20, wdata: 8'h00, stable: 1'b1});
        exp_out_q.push_back(8'h03);
        release_reset();
        run_to_halt("mem_wait", 200, cyc);
        // IDLE 1 + 2 + 2 + SW (3+3) + LW (3+3) + WO 2 + HALT 2
        checks++;
        if (cyc !== 21) begin
            errors++;
            $display("FAIL mem_wait cycles: got %0d required 21", cyc);
        end
        checks++;
        if (imem_addr !== 8'h05 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL mem_wait final: pc=0x%02h dmem_req=%b required pc=0x05 dmem_req=0", imem_addr, dmem_req);
        end
        drain_scoreboard("mem_wait");
    endtask

    task automatic test_jumps();
        int cyc;
        do_reset();
        iwait = 0; dwait = 0;
        put(8'h00, 4'hC, 2'd0, 2'd1, 8'h10);  // JEQ r0,r1 -> 0x10 (taken first pass, not second)
        put(8'h10, 4'h2, 2'd1, 2'd0, 8'h01);  // ADDI r1,1
        put(8'h11, 4'hC, 2'd0, 2'd1, 8'h40);  // JEQ r0,r1 not taken
        put(8'h12, 4'hF, 2'd0, 2'd0, 8'hFF);  // JMP 0xFF
        put(8'hFF, 4'h0, 2'd0, 2'd0, 8'h00);  // NOP, pc wraps to 0x00
        exp_fetch_q = '{8'h00, 8'h10, 8'h11, 8'h12, 8'hFF, 8'h00, 8'h01};
        release_reset();
        run_to_halt("jumps", 200, cyc);
        checks++;
        if (imem_addr !== 8'h01) begin
            errors++;
            $display("FAIL jumps final_pc: got 0x%02h required 0x01", imem_addr);
        end
        drain_scoreboard("jumps");
    endtask

    task automatic test_arith_wrap();
        int cyc;
        do_reset();
        iwait = 1; dwait = 0;
        in_data = 8'hA5;
        put(0,  4'h2, 2'd0, 2'd0, 8'hFF);  // ADDI r0,0xFF
        put(1,  4'h2, 2'd0, 2'd0, 8'h02);  // ADDI r0,0x02 -> 0x01
        put(2,  4'h9, 2'd0, 2'd0, 8'h00);  // WO r0
        put(3,  4'hA, 2'd3, 2'd0, 8'h00);  // RO r3 -> 0xA5
        put(4,  4'h9, 2'd3, 2'd0, 8'h00);  // WO r3
        put(5,  4'h3, 2'd0, 2'd3, 8'h00);  // SUB r0,r3 -> 0x5C
        put(6,  4'h9, 2'd0, 2'd0, 8'h00);  // WO r0
        put(7,  4'h6, 2'd1, 2'd3, 8'h00);  // NOT r1,r3 -> 0x5A
        put(8,  4'hB, 2'd2, 2'd3, 8'h00);  // COPY r2,r3 -> 0xA5
        put(9,  4'h4, 2'd2, 2'd1, 8'h00);  // AND r2,r1 -> 0x00
        put(10, 4'h9, 2'd2, 2'd0, 8'h00);  // WO r2
        put(11, 4'h5, 2'd1, 2'd0, 8'h00);  // OR r1,r0 -> 0x5E
        put(12, 4'h9, 2'd1, 2'd0, 8'h00);  // WO r1
        put(13, 4'hD, 2'd3, 2'd0, 8'h00);  // ZERO r3
        put(14, 4'h9, 2'd3, 2'd0, 8'h00);  // WO r3
        put(15, 4'h1, 2'd0, 2'd0, 8'h00);  // ADD r0,r0 -> 0xB8
        put(16, 4'h9, 2'd0, 2'd0, 8'h00);  // WO r0
        for (int a = 0; a <= 17; a++) exp_fetch_q.push_back(8'(a));
        exp_out_q = '{8'h01, 8'hA5, 8'h5C, 8'h00, 8'h5E, 8'h00, 8'hB8};
        release_reset();
        run_to_halt("arith", 500, cyc);
        drain_scoreboard("arith");
        in_data = 8'h00;
    endtask

    task automatic test_halt();
        int   cyc;
        logic bad;
        do_reset();
        iwait = 0; dwait = 0;
        put(0, 4'hF, 2'd0, 2'd0, 8'h07);   // JMP 0x07, HALT sits at 0x07
        exp_fetch_q = '{8'h00, 8'h07};
        release_reset();
        run_to_halt("halt", 100, cyc);
        checks++;
        if (cyc !== 5) begin
            errors++;
            $display("FAIL halt cycles: got %0d required 5", cyc);
        end
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (imem_req !== 1'b0 || dmem_req !== 1'b0 || halted !== 1'b1 || imem_addr !== 8'h07) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL halt hold: imem_req=%b dmem_req=%b halted=%b pc=0x%02h required 0/0/1/0x07",
                     imem_req, dmem_req, halted, imem_addr);
        end
        drain_scoreboard("halt");
        #2 rst = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL halt reset_release: halted=%b pc=0x%02h required 0/0x00", halted, imem_addr);
        end
        exp_fetch_q = '{8'h00, 8'h07};
        release_reset();
        run_to_halt("halt_restart", 100, cyc);
        drain_scoreboard("halt_restart");
    endtask

    task automatic test_reset_mid_mem();
        int   cyc;
        int   n;
        do_reset();
        iwait = 0; dwait = 10;
        put(0, 4'h8, 2'd0, 2'd0, 8'h00);   // SW mem[r0]<-r0, long wait
        exp_fetch_q.push_back(8'h00);
        release_reset();
        n = 0;
        while (dmem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL abort dmem_req_seen: got %b required 1", dmem_req);
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || imem_req !== 1'b0 || dmem_we !== 1'b0) begin
            errors++;
            $display("FAIL abort same_cycle: dmem_req=%b imem_req=%b dmem_we=%b required 0/0/0",
                     dmem_req, imem_req, dmem_we);
        end
        @(negedge clk);
        #2 dack_force = 1'b1;
        @(negedge clk);
        #2 dack_force = 1'b0;
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0 || imem_addr !== 8'h00 || halted !== 1'b0) begin
            errors++;
            $display("FAIL abort late_ack: dmem_req=%b pc=0x%02h halted=%b required 0/0x00/0",
                     dmem_req, imem_addr, halted);
        end
        drain_scoreboard("abort");
        put(0, 4'hE, 2'd0, 2'd0, 8'h00);   // restart program: HALT at 0
        exp_fetch_q.push_back(8'h00);
        dwait = 0;
        release_reset();
        run_to_halt("abort_restart", 100, cyc);
        checks++;
        if (imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL abort restart_pc: got 0x%02h required 0x00", imem_addr);
        end
        drain_scoreboard("abort_restart");
    endtask

    initial begin
        test_reset();
        test_alu_seq();
        test_mem_wait();
        test_jumps();
        test_arith_wrap();
        test_halt();
        test_reset_mid_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
